imm_operand_encoder: RTL

//  Inverse of the data-processing Val2 path: given a 32-bit constant, finds the
//  ARM 12-bit immediate encoding {rotate[3:0], imm8[7:0]}, where the decoded

---
 rtl/operand_enc_pkg.sv | 30 +++
 rtl/rot_candidate_check.sv | 18 +
 rtl/imm_operand_encoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/operand_enc_pkg.sv
// Shared constants, FSM encoding and rotate helper for the ARM
// immediate operand encoder (imm_operand_encoder).
package operand_enc_pkg;

    localparam int ROT_STEPS = 16;
    localparam int IMM_W     = 8;
    localparam int ROT_W     = 4;
    localparam int SHOP_W    = 12;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef struct packed {
        logic             hit;
        logic [ROT_W-1:0] rot;
        logic [IMM_W-1:0] imm8;
    } enc_pick_t;

    // 32-bit rotate left by 2*r, taken from the top half of a doubled word.
    function automatic logic [31:0] rol32(
        input logic [31:0]      v,
        input logic [ROT_W-1:0] r
    );
        logic [63:0] w_dbl;
        w_dbl = {v, v} << {r, 1'b0};
        return w_dbl[63:32];
    endfunction

endpackage

// File: rtl/rot_candidate_check.sv
// One rotation candidate: does ROL(value, 2r) fit in the low 8 bits?
// Purely combinational; the top instantiates one per tested rotation.
module rot_candidate_check
    import operand_enc_pkg::*;
(
    input  logic [31:0]      value,
    input  logic [ROT_W-1:0] r,
    output logic             fit,
    output logic [IMM_W-1:0] imm8
);

    logic [31:0] w_cand;

    assign w_cand = rol32(value, r);
    assign fit    = (w_cand[31:IMM_W] == '0);
    assign imm8   = w_cand[IMM_W-1:0];

endmodule

// File: rtl/imm_operand_encoder.sv
// Iterative search for the ARM {rotate, imm8} encoding of a constant.
// Define OPENC_INVERT_EN to also search ~value and expose the invert port.
module imm_operand_encoder
    import operand_enc_pkg::*;
#(
    parameter int CANDS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              found,
    output logic [SHOP_W-1:0] shift_operand
`ifdef OPENC_INVERT_EN
    ,
    output logic              invert
`endif
);

    localparam logic [ROT_W-1:0] STEP   = ROT_W'(CANDS_PER_CYCLE);
    localparam logic [ROT_W-1:0] LAST_K = ROT_W'(ROT_STEPS - CANDS_PER_CYCLE);

    logic [1:0]        r_state;
    logic [31:0]       r_value_q;
    logic [ROT_W-1:0]  r_cnt;
    logic              r_found;
    logic [SHOP_W-1:0] r_shop;

    logic [ROT_W-1:0]           w_rot  [CANDS_PER_CYCLE];
    logic [CANDS_PER_CYCLE-1:0] w_dfit;
    logic [IMM_W-1:0]           w_dimm [CANDS_PER_CYCLE];
    enc_pick_t                  w_pick;
    logic                       w_last;

`ifdef OPENC_INVERT_EN
    logic                       r_inv;
    logic [31:0]                w_value_n;
    logic [CANDS_PER_CYCLE-1:0] w_ifit;
    logic [IMM_W-1:0]           w_iimm [CANDS_PER_CYCLE];
    logic                       w_pick_inv;

    assign w_value_n = ~r_value_q;
`endif

    // Rotations within a step never wrap: the counter advances in
    // multiples of CANDS_PER_CYCLE, which divides ROT_STEPS.
    for (genvar g = 0; g < CANDS_PER_CYCLE; g++) begin : g_cand
        assign w_rot[g] = r_cnt + ROT_W'(g);

        rot_candidate_check u_dir (
            .value (r_value_q),
            .r     (w_rot[g]),
            .fit   (w_dfit[g]),
            .imm8  (w_dimm[g])
        );

`ifdef OPENC_INVERT_EN
        rot_candidate_check u_inv (
            .value (w_value_n),
            .r     (w_rot[g]),
            .fit   (w_ifit[g]),
            .imm8  (w_iimm[g])
        );
`endif
    end

    // Walk from the highest slot down so the lowest rotation wins,
    // and a direct fit overrides an inverted fit at the same slot.
    always_comb begin
        w_pick = '0;
`ifdef OPENC_INVERT_EN
        w_pick_inv = 1'b0;
`endif
        for (int i = CANDS_PER_CYCLE - 1; i >= 0; i--) begin
`ifdef OPENC_INVERT_EN
            if (w_ifit[i]) begin
                w_pick     = '{hit: 1'b1, rot: w_rot[i], imm8: w_iimm[i]};
                w_pick_inv = 1'b1;
            end
`endif
            if (w_dfit[i]) begin
                w_pick = '{hit: 1'b1, rot: w_rot[i], imm8: w_dimm[i]};
`ifdef OPENC_INVERT_EN
                w_pick_inv = 1'b0;
`endif
            end
        end
    end

    assign w_last = (r_cnt == LAST_K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_value_q <= '0;
            r_cnt     <= '0;
            r_found   <= 1'b0;
            r_shop    <= '0;
`ifdef OPENC_INVERT_EN
            r_inv     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_value_q <= value;
                        r_cnt     <= '0;
                        r_state   <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (w_pick.hit) begin
                        r_found <= 1'b1;
                        r_shop  <= {w_pick.rot, w_pick.imm8};
`ifdef OPENC_INVERT_EN
                        r_inv   <= w_pick_inv;
`endif
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else if (w_last) begin
                        r_found <= 1'b0;
                        r_shop  <= '0;
`ifdef OPENC_INVERT_EN
                        r_inv   <= 1'b0;
`endif
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + STEP;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (r_state == ST_IDLE);
    assign out_valid     = (r_state == ST_DONE);
    assign found         = r_found;
    assign shift_operand = r_shop;
`ifdef OPENC_INVERT_EN
    assign invert        = r_inv;
`endif

endmodule
